gru_step_sequencer: RTL

//   Control FSM that time-multiplexes one shared signed fixed-point MAC across all six GRU

---
 rtl/gru_step_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gru_step_sequencer.sv
// gru_step_sequencer: control FSM that time-multiplexes one shared MAC across the six
// GRU matrix-vector half-jobs (W_i*x and W_h*h for gates r, z, n) for each timestep.
// Ports:
//   clk, reset (async, active-low)
//   start / seq_len / busy / done        : sequence launch and completion
//   h_init                               : datapath loads initial h
//   x_valid / x_ready                    : x vector input handshake
//   mac_en/first/sel_h/gate/row/col      : MAC strobes and operand select
//   w_addr                               : weight-memory address for the current beat
//   acc_cap                              : accumulator capture after each half-job
//   act_start / act_done                 : activation / h' stage handshake
//   h_we / h_row                         : h register file write-back
//   y_valid / y_ready / step_idx         : y output handshake and current timestep
// Assumes IN_DIM >= HID_DIM so the column counter also covers the h half-job.
module gru_step_sequencer #(
  parameter int unsigned IN_DIM  = 4,
  parameter int unsigned HID_DIM = 2,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ADDR_W  = $clog2(3 * HID_DIM * (IN_DIM + HID_DIM)),
  localparam int unsigned ROW_W  = (HID_DIM > 1) ? $clog2(HID_DIM) : 1,
  localparam int unsigned COL_W  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  output logic              busy,
  output logic              done,
  output logic              h_init,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              mac_en,
  output logic              mac_first,
  output logic              mac_sel_h,
  output logic [1:0]        mac_gate,
  output logic [ROW_W-1:0]  mac_row,
  output logic [COL_W-1:0]  mac_col,
  output logic [ADDR_W-1:0] w_addr,
  output logic              acc_cap,
  output logic              act_start,
  input  logic              act_done,
  output logic              h_we,
  output logic [ROW_W-1:0]  h_row,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [LEN_W-1:0]  step_idx
);

  localparam int unsigned ROW_STRIDE  = IN_DIM + HID_DIM;
  localparam int unsigned GATE_STRIDE = HID_DIM * ROW_STRIDE;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOAD, S_MAC, S_CAP, S_ACT, S_WAIT, S_UPD, S_OUT, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]  seq_len_q, seq_len_d;
  logic [LEN_W-1:0]  step_q, step_d;
  logic [1:0]        gate_q, gate_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              sel_h_q, sel_h_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  hrow_q, hrow_d;

  logic busy_q, busy_d, done_q, done_d, h_init_q, h_init_d, x_ready_q, x_ready_d;
  logic mac_en_q, mac_en_d, mac_first_q, mac_first_d, acc_cap_q, acc_cap_d;
  logic act_start_q, act_start_d, h_we_q, h_we_d, y_valid_q, y_valid_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;

  logic col_last, row_last, gate_last, hrow_last, step_last;

  assign col_last  = (col_q == (sel_h_q ? COL_W'(HID_DIM - 1) : COL_W'(IN_DIM - 1)));
  assign row_last  = (row_q == ROW_W'(HID_DIM - 1));
  assign gate_last = (gate_q == 2'd2);
  assign hrow_last = (hrow_q == ROW_W'(HID_DIM - 1));
  assign step_last = (step_q == (seq_len_q - LEN_W'(1)));

  // Next-state / counter logic; outputs are decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    step_d    = step_q;
    gate_d    = gate_q;
    row_d     = row_q;
    sel_h_d   = sel_h_q;
    col_d     = col_q;
    hrow_d    = hrow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seq_len_d = seq_len;
          step_d    = '0;
          state_d   = (seq_len == '0) ? S_FIN : S_INIT;
        end
      end
      S_INIT: begin
        step_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (x_valid) begin
          gate_d  = '0;
          row_d   = '0;
          sel_h_d = 1'b0;
          col_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (col_last) begin
          col_d   = '0;
          state_d = S_CAP;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      // Advance half -> row -> gate after each accumulator capture.
      S_CAP: begin
        state_d = S_MAC;
        if (!sel_h_q) begin
          sel_h_d = 1'b1;
        end else begin
          sel_h_d = 1'b0;
          if (!row_last) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            row_d = '0;
            if (gate_last) begin
              gate_d  = '0;
              state_d = S_ACT;
            end else begin
              gate_d = gate_q + 2'd1;
            end
          end
        end
      end
      S_ACT: state_d = S_WAIT;
      S_WAIT: begin
        if (act_done) begin
          hrow_d  = '0;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        if (hrow_last) begin
          hrow_d  = '0;
          state_d = S_OUT;
        end else begin
          hrow_d = hrow_q + ROW_W'(1);
        end
      end
      S_OUT: begin
        if (y_ready) begin
          if (step_last) begin
            state_d = S_FIN;
          end else begin
            step_d  = step_q + LEN_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    h_init_d    = (state_d == S_INIT);
    x_ready_d   = (state_d == S_LOAD);
    mac_en_d    = (state_d == S_MAC);
    mac_first_d = (state_d == S_MAC) && (col_d == '0);
    acc_cap_d   = (state_d == S_CAP);
    act_start_d = (state_d == S_ACT);
    h_we_d      = (state_d == S_UPD);
    y_valid_d   = (state_d == S_OUT);
    w_addr_d    = ADDR_W'(gate_d) * ADDR_W'(GATE_STRIDE)
                + ADDR_W'(row_d) * ADDR_W'(ROW_STRIDE)
                + (sel_h_d ? ADDR_W'(IN_DIM) : ADDR_W'(0))
                + ADDR_W'(col_d);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      seq_len_q   <= '0;
      step_q      <= '0;
      gate_q      <= '0;
      row_q       <= '0;
      sel_h_q     <= 1'b0;
      col_q       <= '0;
      hrow_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      h_init_q    <= 1'b0;
      x_ready_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      acc_cap_q   <= 1'b0;
      act_start_q <= 1'b0;
      h_we_q      <= 1'b0;
      y_valid_q   <= 1'b0;
      w_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      seq_len_q   <= seq_len_d;
      step_q      <= step_d;
      gate_q      <= gate_d;
      row_q       <= row_d;
      sel_h_q     <= sel_h_d;
      col_q       <= col_d;
      hrow_q      <= hrow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      h_init_q    <= h_init_d;
      x_ready_q   <= x_ready_d;
      mac_en_q    <= mac_en_d;
      mac_first_q <= mac_first_d;
      acc_cap_q   <= acc_cap_d;
      act_start_q <= act_start_d;
      h_we_q      <= h_we_d;
      y_valid_q   <= y_valid_d;
      w_addr_q    <= w_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign h_init    = h_init_q;
  assign x_ready   = x_ready_q;
  assign mac_en    = mac_en_q;
  assign mac_first = mac_first_q;
  assign mac_sel_h = sel_h_q;
  assign mac_gate  = gate_q;
  assign mac_row   = row_q;
  assign mac_col   = col_q;
  assign w_addr    = w_addr_q;
  assign acc_cap   = acc_cap_q;
  assign act_start = act_start_q;
  assign h_we      = h_we_q;
  assign h_row     = hrow_q;
  assign y_valid   = y_valid_q;
  assign step_idx  = step_q;

endmodule
